// File: rtl/ddr3_tc_pkg.sv
// Shared definitions for the DDR3 traffic checker: FSM encoding, counter
// widths and the per-lane test pattern.
package ddr3_tc_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int LANE_W = 32;
   localparam int IDX_W  = 16;

   // One 32-bit lane of the pattern: beat index and its complement, salted per lane.
   function automatic logic [LANE_W-1:0] lane_word(input logic [IDX_W-1:0]  idx,
                                                   input logic [LANE_W-1:0] seed,
                                                   input logic [LANE_W-1:0] lane);
      lane_word = {~idx, idx} ^ (seed + lane);
   endfunction

endpackage

// File: rtl/ddr3_tc_pattern.sv
// Combinational pattern word for a beat index; shared by the write
// generator and the read-back checker so both agree by construction.
module ddr3_tc_pattern
   import ddr3_tc_pkg::*;
#(
   parameter int          DATA_WIDTH = 128,
   parameter logic [31:0] SEED       = 32'h5A5A_0000
) (
   input  logic [IDX_W-1:0]      idx_i,
   output logic [DATA_WIDTH-1:0] word_o
);
   localparam int LANES = DATA_WIDTH / LANE_W;

   // Build the full beat lane by lane.
   always_comb begin
      word_o = '0;
      for (int k = 0; k < LANES; k++) begin
         word_o[k*LANE_W +: LANE_W] = lane_word(idx_i, SEED, 32'(k));
      end
   end

endmodule

// File: rtl/ddr3_traffic_checker.sv
// DDR3 user-side traffic generator/checker: writes a seeded pattern over an
// address range, reads it back in order, and reports done/pass.
module ddr3_traffic_checker
   import ddr3_tc_pkg::*;
#(
   parameter int          ADDR_WIDTH = 24,
   parameter int          DATA_WIDTH = 128,
   parameter int          NUM_WORDS  = 1024,
   parameter int          START_ADDR = 0,
   parameter int          ADDR_STEP  = 8,
   parameter logic [31:0] SEED       = 32'h5A5A_0000,
   parameter int          TIMEOUT    = 65535
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cal_done,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic                    cmd_we,
   output logic [ADDR_WIDTH-1:0]   cmd_addr,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_mask,
   input  logic                    rd_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic [15:0]             err_cnt,
   output logic [15:0]             first_err_idx,
   output logic                    timeout,
   output logic                    done,
   output logic                    pass
);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0]      TMO_LAST   = IDX_W'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC   = ADDR_WIDTH'(ADDR_STEP);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d, chk_idx_q, chk_idx_d, outst_q, outst_d, tmo_q, tmo_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             err_cnt_q, err_cnt_d, first_err_q, first_err_d;
   logic                    timeout_q, timeout_d, pass_q, pass_d;
   logic                    cmd_valid_q, cmd_we_q, wr_valid_q, done_q;
   logic [DATA_WIDTH-1:0]   wr_data_q, gen_word_s, chk_word_s;
   logic                    active_s, beat_ok_s, rd_acc_s, rd_seen_s, rd_match_s, rd_err_s, tmo_hit_s;

   ddr3_tc_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_gen (.idx_i(idx_d),     .word_o(gen_word_s));
   ddr3_tc_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_chk (.idx_i(chk_idx_q), .word_o(chk_word_s));

   // Handshake and read-back classification for the current cycle.
   always_comb begin
      active_s   = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
      beat_ok_s  = (state_q == ST_WRITE) && cmd_ready && wr_ready;
      rd_acc_s   = (state_q == ST_READ) && cmd_ready;
      rd_seen_s  = ((state_q == ST_READ) || (state_q == ST_DRAIN)) && rd_valid;
      rd_match_s = rd_seen_s && (outst_q != '0);
      // Data with nothing outstanding is an error by itself and is never compared.
      rd_err_s   = rd_seen_s && ((outst_q == '0) || (rd_data != chk_word_s));
      tmo_hit_s  = active_s && !(beat_ok_s || rd_acc_s || rd_valid) && (tmo_q == TMO_LAST);
   end

   // Next-state logic for the sequencer, checker counters and verdict.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (cal_done) begin
               state_d = ST_WRITE;
               idx_d   = '0;
               addr_d  = ADDR_FIRST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE, ST_READ: begin
            if (beat_ok_s || rd_acc_s) begin
               if (idx_q == LAST_IDX) begin
                  state_d = (state_q == ST_WRITE) ? ST_READ : ST_DRAIN;
                  idx_d   = '0;
                  addr_d  = ADDR_FIRST;
               end else begin
                  idx_d  = idx_q + 16'd1;
                  addr_d = addr_q + ADDR_INC;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_DRAIN: begin
            if (outst_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase

      if (tmo_hit_s) begin
         state_d   = ST_DONE;
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_q;
      end

      if (rd_match_s) begin
         chk_idx_d = chk_idx_q + 16'd1;
      end else begin
         chk_idx_d = chk_idx_q;
      end

      case ({rd_acc_s, rd_match_s})
         2'b10:   outst_d = outst_q + 16'd1;
         2'b01:   outst_d = outst_q - 16'd1;
         default: outst_d = outst_q;
      endcase

      if (rd_err_s) begin
         first_err_d = (err_cnt_q == 16'd0) ? chk_idx_q : first_err_q;
         err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      end else begin
         first_err_d = first_err_q;
         err_cnt_d   = err_cnt_q;
      end

      if (!active_s || beat_ok_s || rd_acc_s || rd_valid) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 16'd1;
      end

      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         pass_d = (err_cnt_d == 16'd0) && !timeout_d;
      end else begin
         pass_d = pass_q;
      end
   end

   // State and outputs; outputs are decoded from the next state so they are all registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         chk_idx_q   <= '0;
         outst_q     <= '0;
         tmo_q       <= '0;
         addr_q      <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         timeout_q   <= 1'b0;
         pass_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_we_q    <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         chk_idx_q   <= chk_idx_d;
         outst_q     <= outst_d;
         tmo_q       <= tmo_d;
         addr_q      <= addr_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         timeout_q   <= timeout_d;
         pass_q      <= pass_d;
         cmd_valid_q <= (state_d == ST_WRITE) || (state_d == ST_READ);
         cmd_we_q    <= (state_d == ST_WRITE);
         wr_valid_q  <= (state_d == ST_WRITE);
         wr_data_q   <= (state_d == ST_WRITE) ? gen_word_s : '0;
         done_q      <= (state_d == ST_DONE);
      end
   end

   assign cmd_valid     = cmd_valid_q;
   assign cmd_we        = cmd_we_q;
   assign cmd_addr      = addr_q;
   assign wr_valid      = wr_valid_q;
   assign wr_data       = wr_data_q;
   assign wr_mask       = '0;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_err_q;
   assign timeout       = timeout_q;
   assign done          = done_q;
   assign pass          = pass_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Bench for ddr3_traffic_checker: a behavioural DDR slave with a memory image,
// randomized stalls/latency/corruption, and an expected-result model.
module tb_ddr3_traffic_checker;
   localparam int          AW   = 24;
   localparam int          DW   = 128;
   localparam int          NW   = 16;
   localparam int          STEP = 8;
   localparam int          TMO  = 100;
   localparam int          LAT  = 10;
   localparam logic [31:0] SEED = 32'h5A5A_0000;

   logic          clk = 1'b0;
   logic          reset_n, cal_done, cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready, rd_valid;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic [DW/8-1:0] wr_mask;
   logic [15:0]   err_cnt, first_err_idx;
   logic          timeout, done, pass;

   always #5 clk = ~clk;

   ddr3_traffic_checker #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .START_ADDR(0),
      .ADDR_STEP(STEP), .SEED(SEED), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cal_done(cal_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .timeout(timeout), .done(done), .pass(pass)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // slave / model state
   int            cyc = 0;
   int            rdy_mode = 0;
   int            lat_min = LAT, lat_max = LAT;
   bit            spur_en, spur_done;
   logic [DW-1:0] mem [logic [AW-1:0]];
   int            rq_due[$];
   logic [AW-1:0] rq_addr[$];
   logic [AW-1:0] wr_log[$];
   logic [AW-1:0] rd_log[$];
   logic [DW-1:0] corrupt [NW];
   int            ret_n, rd_issued, last_rd_cyc, first_wr_cyc, last_wr_cyc, exp_err, exp_first;

   function automatic logic [DW-1:0] exp_word(input int i);
      logic [15:0]   x;
      logic [DW-1:0] w;
      x = 16'(i);
      for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = {~x, x} ^ (SEED + 32'(k));
      return w;
   endfunction

   // Behavioural memory slave, acting half a cycle ahead of each rising edge.
   always @(negedge clk) begin
      logic [DW-1:0] d;
      int            due;
      cyc = cyc + 1;
      case (rdy_mode)
         0:       begin cmd_ready = 1'b1; wr_ready = 1'b1; end
         1:       begin cmd_ready = 1'($urandom_range(0, 1)); wr_ready = 1'($urandom_range(0, 1)); end
         default: begin cmd_ready = 1'b0; wr_ready = 1'b1; end
      endcase
      rd_valid = 1'b0;
      rd_data  = '0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         d = mem.exists(rq_addr[0]) ? mem[rq_addr[0]] : '0;
         d = d ^ corrupt[ret_n];
         if (d !== exp_word(ret_n)) begin
            if (exp_err == 0) exp_first = ret_n;
            exp_err++;
         end
         void'(rq_due.pop_front());
         void'(rq_addr.pop_front());
         rd_valid    = 1'b1;
         rd_data     = d;
         ret_n++;
         last_rd_cyc = cyc;
      end else if (spur_en && !spur_done && ret_n == NW && rd_issued == ret_n && cyc == last_rd_cyc + 1) begin
         rd_valid  = 1'b1;
         rd_data   = {4{$urandom}};
         spur_done = 1'b1;
         exp_err++;
      end
      if (reset_n && cmd_valid && cmd_ready) begin
         if (cmd_we) begin
            if (wr_valid && wr_ready) begin
               mem[cmd_addr] = wr_data;
               wr_log.push_back(cmd_addr);
               if (first_wr_cyc < 0) first_wr_cyc = cyc;
               last_wr_cyc = cyc;
            end
         end else begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (rq_due.size() > 0 && due <= rq_due[$]) due = rq_due[$] + 1;
            rq_due.push_back(due);
            rq_addr.push_back(cmd_addr);
            rd_log.push_back(cmd_addr);
            rd_issued++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_slave();
      mem.delete(); rq_due.delete(); rq_addr.delete(); wr_log.delete(); rd_log.delete();
      for (int i = 0; i < NW; i++) corrupt[i] = '0;
      ret_n = 0; rd_issued = 0; last_rd_cyc = -10; first_wr_cyc = -1; last_wr_cyc = -1;
      exp_err = 0; exp_first = 0; spur_en = 1'b0; spur_done = 1'b0;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      cal_done = 1'b0;
      clear_slave();
      repeat (3) step();
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input int bound, output bit got, output int done_cyc);
      got = 1'b0;
      done_cyc = 0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (done) begin
            got = 1'b1;
            done_cyc = cyc;
            break;
         end
      end
   endtask

   function automatic int image_errors();
      int bad = 0;
      if (wr_log.size() != NW || rd_log.size() != NW) bad++;
      for (int i = 0; i < NW && i < wr_log.size() && i < rd_log.size(); i++) begin
         if (wr_log[i] !== AW'(i * STEP) || rd_log[i] !== AW'(i * STEP)) bad++;
         if (!mem.exists(AW'(i * STEP)) || mem[AW'(i * STEP)] !== exp_word(i)) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({cmd_valid, cmd_we, wr_valid, timeout, done, pass} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {cmd_valid, cmd_we, wr_valid, timeout, done, pass});
      else n_pass++;
      n_checks++;
      if (cmd_addr !== '0 || wr_data !== '0 || wr_mask !== '0 || err_cnt !== 16'd0 || first_err_idx !== 16'd0)
         $display("FAIL reset_buses: addr=%h data=%h mask=%h err=%0d first=%0d want all 0", cmd_addr, wr_data, wr_mask, err_cnt, first_err_idx);
      else n_pass++;
      repeat (4) step();
      n_checks++;
      if (cmd_valid !== 1'b0) $display("FAIL idle_wait_cal: cmd_valid=%b want 0", cmd_valid);
      else n_pass++;
      cal_done = 1'b1;
      step();
      n_checks++;
      if ({cmd_valid, cmd_we, wr_valid} !== 3'b111 || cmd_addr !== '0 || wr_data !== exp_word(0))
         $display("FAIL first_cmd_latency: v/we/wv=%b addr=%h data=%h want 111 0 %h", {cmd_valid, cmd_we, wr_valid}, cmd_addr, wr_data, exp_word(0));
      else n_pass++;
   endtask

   task automatic test_ideal();
      bit got; int dc; int bad;
      rdy_mode = 0; lat_min = LAT; lat_max = LAT;
      do_reset();
      cal_done = 1'b1;
      wait_done(500, got, dc);
      n_checks++;
      if (!got || pass !== 1'b1 || timeout !== 1'b0) $display("FAIL ideal_done_pass: done=%b pass=%b timeout=%b want 1 1 0", got, pass, timeout);
      else n_pass++;
      n_checks++;
      if (err_cnt !== 16'd0 || first_err_idx !== 16'd0) $display("FAIL ideal_errs: err=%0d first=%0d want 0 0", err_cnt, first_err_idx);
      else n_pass++;
      bad = image_errors();
      n_checks++;
      if (bad != 0) $display("FAIL ideal_image: %0d bad entries (writes=%0d reads=%0d) want 0", bad, wr_log.size(), rd_log.size());
      else n_pass++;
      n_checks++;
      if (last_wr_cyc - first_wr_cyc != NW - 1) $display("FAIL ideal_throughput: write span %0d cycles want %0d", last_wr_cyc - first_wr_cyc, NW - 1);
      else n_pass++;
      n_checks++;
      if (dc - last_rd_cyc != 1) $display("FAIL done_latency: %0d cycles after last rd_valid want 1", dc - last_rd_cyc);
      else n_pass++;
   endtask

   task automatic test_corrupt_beat5();
      bit got; int dc;
      rdy_mode = 0; lat_min = LAT; lat_max = LAT;
      do_reset();
      corrupt[5] = DW'(1);
      cal_done = 1'b1;
      wait_done(500, got, dc);
      n_checks++;
      if (!got || pass !== 1'b0 || err_cnt !== 16'd1 || first_err_idx !== 16'd5)
         $display("FAIL corrupt_beat5: done=%b pass=%b err=%0d first=%0d want 1 0 1 5", got, pass, err_cnt, first_err_idx);
      else n_pass++;
   endtask

   task automatic test_stalls();
      bit got; int dc; int bad;
      rdy_mode = 1; lat_min = 1; lat_max = 20;
      do_reset();
      cal_done = 1'b1;
      wait_done(3000, got, dc);
      bad = image_errors();
      n_checks++;
      if (!got || pass !== 1'b1 || err_cnt !== 16'd0 || timeout !== 1'b0)
         $display("FAIL stalls_pass: done=%b pass=%b err=%0d timeout=%b want 1 1 0 0", got, pass, err_cnt, timeout);
      else n_pass++;
      n_checks++;
      if (bad != 0) $display("FAIL stalls_image: %0d bad entries (writes=%0d) want 0", bad, wr_log.size());
      else n_pass++;
   endtask

   task automatic test_random_corrupt();
      bit got; int dc;
      for (int r = 0; r < 3; r++) begin
         rdy_mode = 1; lat_min = 1; lat_max = 12;
         do_reset();
         for (int i = 0; i < NW; i++)
            if ($urandom_range(0, 3) == 0) corrupt[i] = DW'(1) << $urandom_range(0, DW - 1);
         cal_done = 1'b1;
         wait_done(3000, got, dc);
         n_checks++;
         if (!got || err_cnt !== 16'(exp_err) || first_err_idx !== 16'(exp_first) || pass !== (exp_err == 0))
            $display("FAIL rand_corrupt[%0d]: done=%b err=%0d first=%0d pass=%b want 1 %0d %0d %b", r, got, err_cnt, first_err_idx, pass, exp_err, exp_first, exp_err == 0);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      bit got; int cnt;
      rdy_mode = 2;
      do_reset();
      cal_done = 1'b1;
      got = 1'b0; cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (done) begin got = 1'b1; break; end
         if (cmd_valid) cnt++;
      end
      n_checks++;
      if (!got || timeout !== 1'b1 || pass !== 1'b0 || cmd_valid !== 1'b0)
         $display("FAIL timeout_flags: done=%b timeout=%b pass=%b cmd_valid=%b want 1 1 0 0", got, timeout, pass, cmd_valid);
      else n_pass++;
      n_checks++;
      if (cnt != TMO) $display("FAIL timeout_cycles: cmd_valid high %0d cycles want %0d", cnt, TMO);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      bit got; int dc; int bad;
      rdy_mode = 0; lat_min = LAT; lat_max = LAT;
      do_reset();
      cal_done = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (rd_issued >= 5) begin got = 1'b1; break; end
      end
      n_checks++;
      if (!got || cmd_valid !== 1'b1 || cmd_we !== 1'b0) $display("FAIL midread_reach: reached=%b cmd_valid=%b cmd_we=%b want 1 1 0", got, cmd_valid, cmd_we);
      else n_pass++;
      reset_n = 1'b0;
      clear_slave();
      step();
      n_checks++;
      if ({cmd_valid, cmd_we, wr_valid, timeout, done, pass} !== 6'b0 || cmd_addr !== '0 || wr_data !== '0 || err_cnt !== 16'd0 || first_err_idx !== 16'd0)
         $display("FAIL midread_reset_outputs: flags=%b addr=%h err=%0d want all 0", {cmd_valid, cmd_we, wr_valid, timeout, done, pass}, cmd_addr, err_cnt);
      else n_pass++;
      repeat (2) step();
      reset_n = 1'b1;
      wait_done(500, got, dc);
      bad = image_errors();
      n_checks++;
      if (!got || pass !== 1'b1 || err_cnt !== 16'd0 || bad != 0)
         $display("FAIL midread_restart: done=%b pass=%b err=%0d image_bad=%0d want 1 1 0 0", got, pass, err_cnt, bad);
      else n_pass++;
   endtask

   task automatic test_spurious_drain();
      bit got; int dc;
      rdy_mode = 0; lat_min = LAT; lat_max = LAT;
      do_reset();
      spur_en = 1'b1;
      cal_done = 1'b1;
      wait_done(500, got, dc);
      n_checks++;
      if (!got || err_cnt !== 16'd1 || pass !== 1'b0)
         $display("FAIL spurious_drain: done=%b err=%0d pass=%b want 1 1 0", got, err_cnt, pass);
      else n_pass++;
   endtask

   initial begin
      reset_n   = 1'b0;
      cal_done  = 1'b0;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;
      clear_slave();
      test_reset();
      test_ideal();
      test_corrupt_beat5();
      test_stalls();
      test_random_corrupt();
      test_timeout();
      test_reset_mid_read();
      test_spurious_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
